// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types for the CPU/video memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, CPU_ACC, VID_ACC, RESP)
//   req_id_e    : requester identity, CPU = 0, VID = 1
//   pick_vid()  : arbitration decision shared by both arbitration modes
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    VID_ACC = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_VID = 1'b1
  } req_id_e;

  // Returns 1 when video wins this arbitration slot. tie_vid decides who
  // wins when both requesters are asking at the same time.
  function automatic logic pick_vid(input logic cpu_req,
                                    input logic vid_req,
                                    input logic tie_vid);
    return vid_req && (!cpu_req || tie_vid);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester arbiter (CPU read/write, video read-only)
// in front of a single synchronous memory port (basic_mem port B).
//
// Ports:
//   clk, reset                : system clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata     : CPU request channel
//   vid_req/addr              : video read request channel
//   mem_rdata                 : memory read data, valid the cycle after the address
//   cpu_gnt, vid_gnt          : one-cycle grant pulses
//   cpu_rvalid, vid_rvalid    : one-cycle read-data-valid pulses
//   rdata                     : read data, qualified by the rvalid pulses
//   mem_addr/wdata/we/re      : memory port-B command
//   dbg_state                 : current FSM state
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate winners on
// simultaneous requests; otherwise the CPU always wins ties.
//
// Handshake: a requester raises X_req with its command stable and keeps it
// high until it sees X_gnt; the grant cycle is the cycle the command is on
// the memory port. Dropping X_req before X_gnt withdraws the request. For a
// read, X_rvalid pulses on the cycle after X_gnt with rdata valid. A req
// still high after its grant counts as a fresh request.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             vid_req,
  input  logic [WIDTH-1:0] vid_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             cpu_gnt,
  output logic             vid_gnt,
  output logic             cpu_rvalid,
  output logic             vid_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  output arb_state_e       dbg_state
);

  arb_state_e       state_q, state_d;
  logic             arb_slot;
  logic             tie_vid;
  logic             take_cpu, take_vid;

  // Command latched at the arbitration edge; drives the memory port.
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic             lat_we;
  req_id_e          lat_id;

  // Arbitration happens only while no access is on the port.
  assign arb_slot = (state_q == IDLE) || (state_q == RESP);

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e last_grant_q;

  // Tie goes to whoever did not win last time.
  assign tie_vid = (last_grant_q == REQ_CPU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= REQ_VID;
    end else if (take_cpu) begin
      last_grant_q <= REQ_CPU;
    end else if (take_vid) begin
      last_grant_q <= REQ_VID;
    end
  end
`else
  assign tie_vid = 1'b0;
`endif

  assign take_vid = arb_slot && pick_vid(cpu_req, vid_req, tie_vid);
  assign take_cpu = arb_slot && cpu_req && !take_vid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, RESP: begin
        if (take_cpu) begin
          state_d = CPU_ACC;
        end else if (take_vid) begin
          state_d = VID_ACC;
        end else begin
          state_d = IDLE;
        end
      end
      CPU_ACC, VID_ACC: state_d = RESP;
      default:          state_d = IDLE;
    endcase
  end

  // Command latch. mem_addr/mem_wdata are driven straight from these, so
  // they naturally hold their last value between accesses. Video grants
  // leave the write data untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_id    <= REQ_CPU;
    end else if (take_cpu) begin
      lat_addr  <= cpu_addr;
      lat_wdata <= cpu_wdata;
      lat_we    <= cpu_we;
      lat_id    <= REQ_CPU;
    end else if (take_vid) begin
      lat_addr  <= vid_addr;
      lat_we    <= 1'b0;
      lat_id    <= REQ_VID;
    end
  end

  // Output logic
  always_comb begin
    cpu_gnt    = (state_q == CPU_ACC);
    vid_gnt    = (state_q == VID_ACC);
    mem_we     = (state_q == CPU_ACC) && lat_we;
    mem_re     = ((state_q == CPU_ACC) || (state_q == VID_ACC)) && !lat_we;
    mem_addr   = lat_addr;
    mem_wdata  = lat_wdata;
    // RESP still carries the command of the access just issued.
    cpu_rvalid = (state_q == RESP) && !lat_we && (lat_id == REQ_CPU);
    vid_rvalid = (state_q == RESP) && !lat_we && (lat_id == REQ_VID);
    // Gated so rdata reads 0 whenever it is not qualified (incl. reset).
    rdata      = (cpu_rvalid || vid_rvalid) ? mem_rdata : '0;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- bench for mem_arbiter with a behavioural memory and a
// transaction-level reference model. Build with or without
// ARB_ROUND_ROBIN_EN; expectations follow the same define.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [W-1:0] cpu_addr = '0, cpu_wdata = '0;
  logic         vid_req = 1'b0;
  logic [W-1:0] vid_addr = '0;
  logic [W-1:0] mem_rdata = '0;
  logic         cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, mem_we, mem_re;
  logic [W-1:0] rdata, mem_addr, mem_wdata;
  arb_state_e   dbg_state;

  mem_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .mem_rdata(mem_rdata),
    .cpu_gnt(cpu_gnt), .vid_gnt(vid_gnt), .cpu_rvalid(cpu_rvalid), .vid_rvalid(vid_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA5C3);
  endfunction

  // ---------------- memory (environment) ----------------
  logic [W-1:0] env_mem [int];
  logic [W-1:0] env_rd;
  always @(posedge clk) begin
    env_rd = env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : init_val(mem_addr);
    if (mem_we) env_mem[int'(mem_addr)] = mem_wdata;
    mem_rdata <= env_rd;
  end

  // ---------------- reference model + scoreboard ----------------
  // An access occupies the port for one cycle and is followed by one response
  // cycle; a new winner is chosen only when no access was on the port in the
  // current cycle.
  typedef struct packed {
    logic         v;
    logic         vid;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } txn_t;

  txn_t         cur_t  = '0;
  txn_t         prev_t = '0;
  txn_t         nxt_t;
  logic [W-1:0] hold_addr = '0;
  logic         last_vid  = 1'b1;
  logic         win_vid;
  logic [W-1:0] shadow [int];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rd;

  always @(negedge clk) begin
    if (reset) begin
      check_eq("rst_cpu_gnt", cpu_gnt, 0);
      check_eq("rst_vid_gnt", vid_gnt, 0);
      check_eq("rst_cpu_rvalid", cpu_rvalid, 0);
      check_eq("rst_vid_rvalid", vid_rvalid, 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_re", mem_re, 0);
      check_eq("rst_state", dbg_state, IDLE);
      cur_t     = '0;
      prev_t    = '0;
      hold_addr = '0;
      last_vid  = 1'b1;
      exp_q.delete();
    end else begin
      check_eq("cpu_gnt", cpu_gnt, cur_t.v && !cur_t.vid);
      check_eq("vid_gnt", vid_gnt, cur_t.v && cur_t.vid);
      check_eq("mem_we", mem_we, cur_t.v && !cur_t.vid && cur_t.we);
      check_eq("mem_re", mem_re, cur_t.v && !cur_t.we);
      check_eq("mem_addr", mem_addr, cur_t.v ? cur_t.addr : hold_addr);
      if (cur_t.v && cur_t.we) check_eq("mem_wdata", mem_wdata, cur_t.wdata);
      check_eq("cpu_rvalid", cpu_rvalid, prev_t.v && !prev_t.we && !prev_t.vid);
      check_eq("vid_rvalid", vid_rvalid, prev_t.v && !prev_t.we && prev_t.vid);
      if (prev_t.v && !prev_t.we) begin
        check_eq("rdata_q", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          exp_rd = exp_q.pop_front();
          check_eq("rdata", rdata, exp_rd);
        end
      end

      // Retire the access shown in this cycle into the shadow memory.
      if (cur_t.v) begin
        hold_addr = cur_t.addr;
        if (cur_t.we) begin
          shadow[int'(cur_t.addr)] = cur_t.wdata;
        end else begin
          exp_q.push_back(shadow.exists(int'(cur_t.addr)) ? shadow[int'(cur_t.addr)]
                                                         : init_val(cur_t.addr));
        end
      end

      // Decide what the next cycle shows from the inputs seen at the next edge.
      nxt_t = '0;
      if (!cur_t.v && (cpu_req || vid_req)) begin
        if (cpu_req && vid_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          win_vid = !last_vid;
`else
          win_vid = 1'b0;
`endif
        end else begin
          win_vid = vid_req;
        end
        nxt_t.v     = 1'b1;
        nxt_t.vid   = win_vid;
        nxt_t.we    = win_vid ? 1'b0 : cpu_we;
        nxt_t.addr  = win_vid ? vid_addr : cpu_addr;
        nxt_t.wdata = cpu_wdata;
        last_vid    = win_vid;
      end
      prev_t = cur_t;
      cur_t  = nxt_t;
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers change inputs 2 time units after the rising edge.
  task automatic do_reset();
    reset   = 1'b1;
    cpu_req = 1'b0;
    vid_req = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic cpu_access(input logic we, input logic [W-1:0] addr,
                            input logic [W-1:0] wdata, output int cycles);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    cycles = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #2;
      cycles++;
      if (cpu_gnt) break;
    end
    check_eq("cpu_gnt_wait", cpu_gnt, 1);
    cpu_req = 1'b0;
  endtask

  // Idle-arbiter read: grant one cycle after the request, data the cycle after.
  task automatic cpu_read_expect(input string tag, input logic [W-1:0] addr,
                                 input logic [W-1:0] exp);
    int lat;
    cpu_access(1'b0, addr, '0, lat);
    check_eq({tag, "_lat"}, lat, 1);
    check_eq({tag, "_mem_re"}, mem_re, 1);
    check_eq({tag, "_mem_addr"}, mem_addr, addr);
    @(posedge clk); #2;
    check_eq({tag, "_rvalid"}, cpu_rvalid, 1);
    check_eq({tag, "_rdata"}, rdata, exp);
  endtask

  task automatic new_cpu();
    cpu_we    = ($urandom_range(0, 1) == 1);
    cpu_addr  = 16'h0100 + 16'($urandom_range(0, 7));
    cpu_wdata = 16'($urandom);
    cpu_req   = 1'b1;
  endtask

  task automatic new_vid();
    vid_addr = 16'h0100 + 16'($urandom_range(0, 7));
    vid_req  = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           lat;
    int           gcount;
    logic [3:0]   seq;
    logic         exp_g;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Load from an idle arbiter.
    cpu_read_expect("ld10", 16'h0010, 16'h1234);

    // Store, no read response, then read it back.
    cpu_access(1'b1, 16'h0020, 16'hBEEF, lat);
    check_eq("st_mem_we", mem_we, 1);
    check_eq("st_mem_wdata", mem_wdata, 16'hBEEF);
    @(posedge clk); #2;
    check_eq("st_no_rvalid", cpu_rvalid, 0);
    check_eq("st_we_done", mem_we, 0);
    cpu_read_expect("ld20", 16'h0020, 16'hBEEF);

    // Both requesters held for 8 cycles from a fresh reset.
    do_reset();
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    vid_addr = 16'h0100; vid_req = 1'b1;
    gcount = 0;
    seq    = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      if (cpu_gnt || vid_gnt) begin
        if (gcount < 4) seq[gcount] = vid_gnt;
        gcount++;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    check_eq("tie_count", gcount, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = k[0];
`else
      exp_g = 1'b0;
`endif
      check_eq("tie_grant", seq[k], exp_g);
    end
    repeat (2) @(posedge clk); #2;

    // Video read racing a CPU store to the same word; CPU granted first.
    do_reset();
    cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hCAFE; cpu_req = 1'b1;
    vid_addr = 16'h0100; vid_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #2;
      if (cpu_gnt || vid_gnt) break;
    end
    check_eq("race_cpu_first", cpu_gnt, 1);
    cpu_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #2;
      if (vid_gnt) break;
    end
    check_eq("vid_gnt_wait", vid_gnt, 1);
    check_eq("vid_no_we", mem_we, 0);
    vid_req = 1'b0;
    @(posedge clk); #2;
    check_eq("vid_rvalid", vid_rvalid, 1);
    check_eq("vid_rdata", rdata, 16'hCAFE);

    // Reset in the middle of an access.
    cpu_access(1'b0, 16'h0020, '0, lat);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_gnt", cpu_gnt, 0);
    check_eq("mid_rst_re", mem_re, 0);
    check_eq("mid_rst_addr", mem_addr, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    check_eq("mid_rst_no_rvalid", cpu_rvalid, 0);
    @(posedge clk); #2;
    check_eq("mid_rst_no_rvalid2", cpu_rvalid, 0);
    cpu_read_expect("post_rst", 16'h0020, 16'hBEEF);

    // Randomized traffic: forfeits, back-to-back requests, contention.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #2;
      if (cpu_req) begin
        if (cpu_gnt) begin
          cpu_req = 1'b0;
          if ($urandom_range(0, 1) == 1) new_cpu();
        end else if ($urandom_range(0, 15) == 0) begin
          cpu_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        new_cpu();
      end
      if (vid_req) begin
        if (vid_gnt) begin
          vid_req = 1'b0;
          if ($urandom_range(0, 1) == 1) new_vid();
        end else if ($urandom_range(0, 15) == 0) begin
          vid_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        new_vid();
      end
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
